// File: rtl/bus_grant_encoder.sv
// bus_grant_encoder
// Purpose: arbitrates 24 bus-drive requests into a single registered one-hot
//          grant plus its binary select code for the bus multiplexer. A grant
//          is held while its request stays high, up to MAX_HOLD cycles. A
//          source that hits the limit is masked until its request drops.
// Ports:
//   clk     in   1   rising-edge clock
//   clr     in   1   synchronous active-high reset
//   req     in  24   bus-drive requests (bit i = source code i)
//   sel     out  5   registered binary code of the granted source
//   grant   out 24   registered one-hot grant
//   busy    out  1   high while a grant is active
//   timeout out  1   sticky: some source hit the hold limit
// Configuration: define BUS_RR_ARB_EN for round-robin arbitration.
//                When it is undefined, the lowest index has fixed priority.
module bus_grant_encoder #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [23:0] req,
    output logic [4:0]  sel,
    output logic [23:0] grant,
    output logic        busy,
    output logic        timeout
);

    localparam int unsigned N_SRC = 24;
    localparam int unsigned SEL_W = 5;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e             state_q, state_d;
    logic [N_SRC-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef BUS_RR_ARB_EN
    logic [SEL_W-1:0]   ptr_q, ptr_d;
`endif

    logic [N_SRC-1:0]   elig_c;
    logic               win_vld_c;
    logic [SEL_W-1:0]   win_idx_c;

    // Pick the winning eligible source (masked sources are excluded)
    always_comb begin
        elig_c    = req & ~mask_q;
        win_vld_c = 1'b0;
        win_idx_c = '0;
`ifdef BUS_RR_ARB_EN
        // Search starts one past the last grant and wraps 23 -> 0
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (!win_vld_c && elig_c[SEL_W'((int'(ptr_q) + 1 + i) % int'(N_SRC))]) begin
                win_vld_c = 1'b1;
                win_idx_c = SEL_W'((int'(ptr_q) + 1 + i) % int'(N_SRC));
            end
        end
`else
        // Walk downward so the lowest set index is the last one written
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (elig_c[i]) begin
                win_vld_c = 1'b1;
                win_idx_c = SEL_W'(i);
            end
        end
`endif
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = timeout_q;
        // A mask bit survives only while its request stays high
        mask_d    = mask_q & req;
        cnt_d     = cnt_q;
`ifdef BUS_RR_ARB_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld_c) begin
                    state_d = BUSY;
                    grant_d = N_SRC'(1) << win_idx_c;
                    sel_d   = win_idx_c;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
`ifdef BUS_RR_ARB_EN
                    ptr_d   = win_idx_c;
`endif
                end
            end
            BUSY: begin
                if (!req[sel_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == HOLD_LAST) begin
                    // Forced release; sel keeps its value as for a normal release
                    state_d        = IDLE;
                    grant_d        = '0;
                    busy_d         = 1'b0;
                    timeout_d      = 1'b1;
                    mask_d[sel_q]  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            mask_q    <= '0;
            cnt_q     <= '0;
`ifdef BUS_RR_ARB_EN
            ptr_q     <= SEL_W'(N_SRC - 1);
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
`ifdef BUS_RR_ARB_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign sel     = sel_q;
    assign grant   = grant_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
